// File: rtl/park_pkg.sv
// ---------------------------------------------------------------------------
// park_pkg
// Shared definitions for the parking-lot occupancy controller and its
// 4-digit display scanner.
//   - Letter codes understood by the downstream seven_seg decoder.
//   - The two messages, stored with index 3 as the leftmost character.
//   - Digit index type used by the scanner.
//   - AN_OFF: all digits dark. Only the bench uses it, as a reference pattern.
// ---------------------------------------------------------------------------
package park_pkg;

    localparam logic [3:0] CODE_L = 4'd0;
    localparam logic [3:0] CODE_U = 4'd1;
    localparam logic [3:0] CODE_F = 4'd2;
    localparam logic [3:0] CODE_O = 4'd3;
    localparam logic [3:0] CODE_P = 4'd4;
    localparam logic [3:0] CODE_E = 4'd5;
    localparam logic [3:0] CODE_n = 4'd6;

    // The first element of the concatenation lands in index 3, which is the
    // leftmost digit. Both messages therefore read naturally left to right.
    localparam logic [3:0][3:0] MSG_OPEN = {CODE_O, CODE_P, CODE_E, CODE_n};
    localparam logic [3:0][3:0] MSG_FULL = {CODE_F, CODE_U, CODE_L, CODE_L};

    localparam logic [3:0] AN_OFF = 4'b1111;

    typedef enum logic [1:0] {
        DIGIT_0 = 2'd0,
        DIGIT_1 = 2'd1,
        DIGIT_2 = 2'd2,
        DIGIT_3 = 2'd3
    } digit_t;

    // The anodes are active-low. Exactly one bit is pulled low, at the
    // position of the selected digit.
    function automatic logic [3:0] anodeFor(input digit_t idx);
        return ~(4'b0001 << idx);
    endfunction

    // Returns the character shown at a given digit position for the
    // current mode.
    function automatic logic [3:0] msgChar(input logic isFull, input digit_t idx);
        return isFull ? MSG_FULL[idx] : MSG_OPEN[idx];
    endfunction

endpackage

// File: rtl/park_edge_det.sv
// ---------------------------------------------------------------------------
// park_edge_det
// Rising-edge detector for an already-synchronised sensor level.
// The history register resets to 1. As a result, a sensor that is still
// high when reset is released does not produce a spurious rising edge.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  synchronous active-low reset
//   sig_i   in  sensor level
//   rise_o  out one-cycle combinational pulse when sig_i goes 0 -> 1
// ---------------------------------------------------------------------------
module park_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // The history register follows the input level every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/park_disp_ctrl.sv
// ---------------------------------------------------------------------------
// park_disp_ctrl
// Counts cars in a lot and scans "OPEn" or "FULL" onto a common-anode
// 4-digit display.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  synchronous active-low reset
//   car_in   in  entry sensor level (debounced, synchronous)
//   car_out  in  exit sensor level (debounced, synchronous)
//   count    out registered occupancy, saturating at 0 and CAPACITY
//   full     out registered, high when count == CAPACITY
//   display  out letter code for the current digit (0..6)
//   an       out active-low one-hot digit enable, an[3] = leftmost
// ---------------------------------------------------------------------------
module park_disp_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_in,
    input  logic             car_out,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic [3:0]       display,
    output logic [3:0]       an
);

    localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic             riseIn;
    logic             riseOut;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic [REF_W-1:0] refresh_q, refresh_d;
    digit_t           digit_q, digit_d;
    logic [3:0]       an_q;
    logic [3:0]       display_q;

    park_edge_det u_edgeIn (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (car_in),
        .rise_o (riseIn)
    );

    park_edge_det u_edgeOut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (car_out),
        .rise_o (riseOut)
    );

    // Next-state logic for the occupancy count and the refresh scanner.
    // An entry and an exit in the same cycle cancel each other. full is
    // derived from the next count so that it is registered together with
    // count and never lags it by a cycle.
    always_comb begin
        count_d = count_q;
        if (riseIn && !riseOut && (count_q < CNT_W'(CAPACITY))) begin
            count_d = count_q + CNT_W'(1);
        end else if (riseOut && !riseIn && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
        full_d = (count_d == CNT_W'(CAPACITY));

        refresh_d = refresh_q + REF_W'(1);
        digit_d   = digit_q;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            digit_d   = digit_t'(digit_q + 2'd1);
        end
    end

    // All state is held in a single register bank. an and display are both
    // loaded from the next digit index on the same edge, so they can never
    // disagree for a cycle. display reads the registered full. A mode change
    // therefore appears one cycle after full changes, wherever the scan is.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            full_q    <= 1'b0;
            refresh_q <= '0;
            digit_q   <= DIGIT_0;
            an_q      <= 4'b1110;
            display_q <= CODE_n;
        end else begin
            count_q   <= count_d;
            full_q    <= full_d;
            refresh_q <= refresh_d;
            digit_q   <= digit_d;
            an_q      <= anodeFor(digit_d);
            display_q <= msgChar(full_q, digit_d);
        end
    end

    assign count   = count_q;
    assign full    = full_q;
    assign display = display_q;
    assign an      = an_q;

endmodule

// File: tb/tb_park_disp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_park_disp_ctrl
// Directed bench for park_disp_ctrl with CAPACITY=3 and REFRESH_DIV=4.
// Inputs change 1 time unit after a rising edge. Outputs are checked at the
// same point, so each check sees the state left by the edge just taken.
// ---------------------------------------------------------------------------
module tb_park_disp_ctrl;
    import park_pkg::*;

    localparam int CAP = 3;
    localparam int DIV = 4;
    localparam int CW  = 8;

    logic          clk;
    logic          rst_n;
    logic          car_in;
    logic          car_out;
    logic [CW-1:0] count;
    logic          full;
    logic [3:0]    display;
    logic [3:0]    an;

    int vectorCount;
    int miscompareCount;
    int cyc;

    logic [3:0] anTab   [4];
    logic [3:0] openTab [4];
    logic [3:0] fullTab [4];

    park_disp_ctrl #(
        .CAPACITY    (CAP),
        .REFRESH_DIV (DIV),
        .CNT_W       (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .car_in  (car_in),
        .car_out (car_out),
        .count   (count),
        .full    (full),
        .display (display),
        .an      (an)
    );

    // The clock has a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through this task, which also counts it.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Sets the sensor levels, takes one rising edge, and settles 1 unit past it.
    task automatic applyStimulus(input logic ci, input logic co);
        car_in  = ci;
        car_out = co;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Takes a reset edge while car_in is held at ci, then releases reset.
    task automatic doReset(input logic ci);
        rst_n   = 1'b0;
        car_in  = ci;
        car_out = 1'b0;
        @(posedge clk);
        #1;
        cyc   = 0;
        rst_n = 1'b1;
    endtask

    // The digit index advances every DIV edges counted from the reset edge.
    function automatic int expIdx();
        return (cyc / DIV) % 4;
    endfunction

    // Checks an and display for the expected index.
    // fullSeen is the registered full from the previous cycle.
    task automatic checkScan(input string tag, input logic fullSeen);
        checkOutput({tag, "_an"}, int'(an), int'(anTab[expIdx()]));
        checkOutput({tag, "_disp"}, int'(display),
                    int'(fullSeen ? fullTab[expIdx()] : openTab[expIdx()]));
    endtask

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        cyc             = 0;
        rst_n           = 1'b0;
        car_in          = 1'b0;
        car_out         = 1'b0;

        anTab[0] = 4'b1110; anTab[1] = 4'b1101; anTab[2] = 4'b1011; anTab[3] = 4'b0111;
        openTab[0] = 4'd6;  openTab[1] = 4'd5;  openTab[2] = 4'd4;  openTab[3] = 4'd3;
        fullTab[0] = 4'd0;  fullTab[1] = 4'd0;  fullTab[2] = 4'd1;  fullTab[3] = 4'd2;

        // Test 1: reset state, then two full scan rotations.
        doReset(1'b0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_an", int'(an), 4'b1110);
        checkOutput("rst_disp", int'(display), 6);
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkScan("scan", 1'b0);
            checkOutput("scan_onehot", int'($countones(an ^ AN_OFF)), 1);
        end
        checkOutput("t1_count", int'(count), 0);
        checkOutput("t1_full", int'(full), 0);

        // Test 2: three entries fill the lot.
        applyStimulus(1'b1, 1'b0);
        checkOutput("in1_count", int'(count), 1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("in2_count", int'(count), 2);
        checkOutput("in2_full", int'(full), 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("in3_count", int'(count), 3);
        checkOutput("in3_full", int'(full), 1);
        checkScan("in3_lag", 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkScan("full_msg", 1'b1);

        // Test 3: an entry while full saturates; an exit reopens the lot.
        applyStimulus(1'b1, 1'b0);
        checkOutput("sat_count", int'(count), 3);
        checkOutput("sat_full", int'(full), 1);
        applyStimulus(1'b0, 1'b0);
        checkScan("sat_msg", 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("out_count", int'(count), 2);
        checkOutput("out_full", int'(full), 0);
        checkScan("out_lag", 1'b1);
        applyStimulus(1'b0, 1'b0);
        checkScan("reopen_msg", 1'b0);

        // Test 4: an exit at zero does not underflow; a held entry counts once.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("drain_count", int'(count), 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("underflow_count", int'(count), 0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0);
        end
        checkOutput("held_count", int'(count), 1);
        applyStimulus(1'b0, 1'b0);

        // Test 5: a simultaneous entry and exit leave the count unchanged.
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_count", int'(count), 1);
        applyStimulus(1'b0, 1'b0);
        checkScan("both_msg", 1'b0);

        // Test 6: car_in held across reset release, then a reset mid-digit-2.
        doReset(1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("held_rst_count", int'(count), 0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pre_rst_count", int'(count), 2);
        for (int i = 0; i < 20 && (expIdx() != 2 || (cyc % DIV) == 0); i++) begin
            applyStimulus(1'b0, 1'b0);
        end
        checkScan("pre_rst_scan", 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("mid_rst_count", int'(count), 0);
        checkOutput("mid_rst_full", int'(full), 0);
        checkOutput("mid_rst_an", int'(an), 4'b1110);
        checkOutput("mid_rst_disp", int'(display), 6);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
